t2mi_packet_generator: RTL and testbench
========================================

T2MI_PACKET_GENERATOR -- requirements
Module: t2mi_packet_generator

Interface
REQ-001 SHALL have a parameter MIN_LEN, default 4, giving the minimum accepted payload length in bytes.
REQ-002 SHALL have a parameter MAX_LEN, default 4096, giving the maximum accepted payload length in bytes.
REQ-003 SHALL have a parameter IDLE_GAP, default 0, giving the number of forced idle cycles after each packet.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the port pkt_req, input, 1 bit: packet send request, level, held until pkt_ack.
REQ-007 SHALL have the port pkt_type, input, 8 bits: packet type, sampled with pkt_req.
REQ-008 SHALL have the port pkt_length, input, 16 bits: payload byte count, sampled with pkt_req.
REQ-009 SHALL have the port pkt_ack, output, 1 bit: one-cycle pulse when a request is consumed, whether accepted or rejected.
REQ-010 SHALL have the port pld_valid, input, 1 bit: payload byte available.
REQ-011 SHALL have the port pld_data, input, 8 bits: payload byte.
REQ-012 SHALL have the port pld_ready, output, 1 bit: generator takes pld_data when pld_valid and pld_ready are both high.
REQ-013 SHALL have the port t2mi_valid, output, 1 bit: output byte valid.
REQ-014 SHALL have the port t2mi_data, output, 8 bits: output byte.
REQ-015 SHALL have the port t2mi_sync, output, 1 bit: high only with the 0x47 sync byte.
REQ-016 SHALL have the port t2mi_ready, input, 1 bit: downstream accepts a byte when t2mi_valid and t2mi_ready are both high.
REQ-017 SHALL have the port busy, output, 1 bit: high in every state other than IDLE.
REQ-018 SHALL have the port gen_error, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-019 SHALL have the port pkt_count, output, 16 bits: number of completed packets, wrapping modulo 2^16.

Function
REQ-020 SHALL implement the states IDLE, SYNC, TYPE, LEN_HI, LEN_LO, PAYLOAD and GAP.
REQ-021 In IDLE with pkt_req high, if MIN_LEN <= pkt_length <= MAX_LEN, SHALL latch type and length, pulse pkt_ack, and enter SYNC on the next cycle.
REQ-022 In IDLE with pkt_req high and pkt_length out of range, SHALL pulse pkt_ack and gen_error in the same cycle and remain in IDLE with no output byte.
REQ-023 The sync byte SHALL be valid on t2mi_data on the cycle after acceptance, which is one cycle of latency.
REQ-024 The emitted byte sequence SHALL be 0x47 with t2mi_sync=1, then type, length[15:8], length[7:0], then exactly length payload bytes, all with t2mi_sync=0.
REQ-025 Each byte SHALL be registered, and t2mi_data/t2mi_sync SHALL hold stable while t2mi_valid=1 and t2mi_ready=0.
REQ-026 The state SHALL advance only on an output transfer; with t2mi_ready held high, the header takes 4 consecutive cycles.
REQ-027 In PAYLOAD, pld_ready SHALL equal (!t2mi_valid | t2mi_ready) while the remaining count is greater than 0; pld_ready SHALL be 0 in all other states.
REQ-028 A payload take SHALL load the output register on the next edge; if pld_valid=0, t2mi_valid SHALL drop to 0 (bubble) with no byte lost, duplicated or reordered.
REQ-029 The remaining counter SHALL be 16 bits and decrement per payload take; the counter reaching 0 ends pld_ready for this packet.
REQ-030 On transfer of the last payload byte, SHALL increment pkt_count (0xFFFF wraps to 0x0000) and enter GAP if IDLE_GAP>0, otherwise IDLE.
REQ-031 GAP SHALL hold t2mi_valid=0 for exactly IDLE_GAP cycles, ignore pkt_req, and then enter IDLE.
REQ-032 pkt_req asserted outside IDLE SHALL be ignored, with no pkt_ack, until IDLE is reached.
REQ-033 With IDLE_GAP=0, back-to-back requests SHALL produce at most 1 idle cycle (the IDLE acceptance cycle) between the last payload byte and the next sync byte.

Reset
REQ-034 While rst_n=0, SHALL asynchronously force state=IDLE, t2mi_valid=0, t2mi_data=0x00, t2mi_sync=0, pkt_ack=0, pld_ready=0, busy=0, gen_error=0, pkt_count=0, and clear the latched type, length and counters.
REQ-035 Reset asserted mid-packet SHALL abandon the packet; after release, the next accepted request SHALL start cleanly with 0x47.

Verification
REQ-036 A bench SHALL cover: type 0x10, len 10, payload 0xAA..0xB3, t2mi_ready=1 -> stream 47(sync=1),10,00,0A,AA..B3 on consecutive cycles; pkt_ack one pulse; pkt_count=1.
REQ-037 A bench SHALL cover: len 2, then len MAX_LEN+1 -> gen_error and pkt_ack pulse each time; t2mi_valid stays 0; pkt_count unchanged.
REQ-038 A bench SHALL cover: type 0x30, len 100, t2mi_ready random 50% -> exactly 104 transfers in order, data stable during stalls, last byte 0x0D (0xAA+99 mod 256).
REQ-039 A bench SHALL cover: len 4 with pld_valid low for 3 cycles mid-payload -> t2mi_valid bubbles, bytes AA..AD delivered in order; len=MIN_LEN accepted.
REQ-040 A bench SHALL cover: IDLE_GAP=2, two back-to-back requests (0x40/15, 0x50/4) -> at least 3 cycles with t2mi_valid=0 between packets; pkt_count=2.
REQ-041 A bench SHALL cover: rst_n pulsed low during the payload of len 20 -> outputs zero immediately; a following 0x20/5 packet is emitted correctly from 0x47.

Source files
------------

// File: rtl/t2mi_packet_generator.sv
// T2-MI packet framer: 0x47 sync, type, 16-bit length, then the payload bytes,
// all presented through one registered output byte with valid/ready handshaking.
module t2mi_packet_generator #(
  parameter int MIN_LEN  = 4,
  parameter int MAX_LEN  = 4096,
  parameter int IDLE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_req,
  input  logic [7:0]  pkt_type,
  input  logic [15:0] pkt_length,
  output logic        pkt_ack,
  input  logic        pld_valid,
  input  logic [7:0]  pld_data,
  output logic        pld_ready,
  output logic        t2mi_valid,
  output logic [7:0]  t2mi_data,
  output logic        t2mi_sync,
  input  logic        t2mi_ready,
  output logic        busy,
  output logic        gen_error,
  output logic [15:0] pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_TYPE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_GAP
  } state_e;

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IDLE_GAP);

  state_e             state_q, state_d;
  logic [7:0]         type_q, type_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               vld_q, vld_d;
  logic [7:0]         data_q, data_d;
  logic               sync_q, sync_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               xfer;
  logic               len_ok;
  logic               pkt_done;
  logic [31:0]        len_ext;

  assign xfer    = vld_q & t2mi_ready;
  assign len_ext = {16'd0, pkt_length};
  assign len_ok  = (len_ext >= 32'(MIN_LEN)) && (len_ext <= 32'(MAX_LEN));

  // The state names the byte sitting in the output register; PAYLOAD is entered
  // as soon as the length low byte is loaded so the first payload take overlaps
  // its transfer and the stream has no bubble at the header/payload seam.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    len_d     = len_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    vld_d     = vld_q;
    data_d    = data_q;
    sync_d    = sync_q;
    cnt_d     = cnt_q;
    pkt_ack   = 1'b0;
    gen_error = 1'b0;
    pld_ready = 1'b0;
    pkt_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pkt_req && rst_n) begin
          pkt_ack = 1'b1;
          if (len_ok) begin
            type_d  = pkt_type;
            len_d   = pkt_length;
            rem_d   = pkt_length;
            data_d  = 8'h47;
            sync_d  = 1'b1;
            vld_d   = 1'b1;
            state_d = S_SYNC;
          end else begin
            gen_error = 1'b1;
          end
        end
      end
      S_SYNC: begin
        if (xfer) begin
          data_d  = type_q;
          sync_d  = 1'b0;
          state_d = S_TYPE;
        end
      end
      S_TYPE: begin
        if (xfer) begin
          data_d  = len_q[15:8];
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          data_d  = len_q[7:0];
          state_d = (rem_q == 16'd0) ? S_LEN_LO : S_PAYLOAD;
        end
      end
      // Only reached for a zero-length packet (possible when MIN_LEN is 0).
      S_LEN_LO: begin
        if (xfer) pkt_done = 1'b1;
      end
      S_PAYLOAD: begin
        pld_ready = (rem_q != 16'd0) && (!vld_q || t2mi_ready);
        if (pld_ready && pld_valid) begin
          data_d = pld_data;
          vld_d  = 1'b1;
          rem_d  = rem_q - 16'd1;
        end else if (xfer) begin
          vld_d = 1'b0;
          if (rem_q == 16'd0) pkt_done = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) state_d = S_IDLE;
        else                    gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (pkt_done) begin
      vld_d   = 1'b0;
      cnt_d   = cnt_q + 16'd1;
      gap_d   = GAP_INIT;
      state_d = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
    end
  end

  assign t2mi_valid = vld_q;
  assign t2mi_data  = data_q;
  assign t2mi_sync  = sync_q;
  assign busy       = (state_q != S_IDLE);
  assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_t2mi_packet_generator.sv
// Bench for t2mi_packet_generator: randomized handshakes against a byte-stream
// model derived directly from the packet format.
module tb_t2mi_packet_generator;
  localparam int MIN_LEN  = 4;
  localparam int MAX_LEN  = 4096;
  localparam int IDLE_GAP = 2;

  logic        clk = 1'b0, rst_n = 1'b0, pkt_req = 1'b0;
  logic [7:0]  pkt_type = '0;
  logic [15:0] pkt_length = '0;
  logic        pld_valid = 1'b0;
  logic [7:0]  pld_data = '0;
  logic        t2mi_ready = 1'b0;
  logic        pkt_ack, pld_ready, t2mi_valid, t2mi_sync, busy, gen_error;
  logic [7:0]  t2mi_data;
  logic [15:0] pkt_count;

  int errors = 0, checks = 0, cyc = 0, exp_cnt = 0;
  logic [8:0] obs_q[$];
  int acks, errs, stall_bad, bubbles, vld_seen, first_cyc, last_cyc, ack_cyc;
  bit timed_out;

  t2mi_packet_generator #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_req(pkt_req), .pkt_type(pkt_type),
    .pkt_length(pkt_length), .pkt_ack(pkt_ack), .pld_valid(pld_valid),
    .pld_data(pld_data), .pld_ready(pld_ready), .t2mi_valid(t2mi_valid),
    .t2mi_data(t2mi_data), .t2mi_sync(t2mi_sync), .t2mi_ready(t2mi_ready),
    .busy(busy), .gen_error(gen_error), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference stream: {sync, byte} at position k of a packet.
  function automatic logic [8:0] exp_byte(logic [7:0] typ, logic [15:0] len, int k);
    case (k)
      0:       return 9'h147;
      1:       return {1'b0, typ};
      2:       return {1'b0, len[15:8]};
      3:       return {1'b0, len[7:0]};
      default: return {1'b0, 8'((32'hAA + k - 4) % 256)};
    endcase
  endfunction

  // Drives one request plus its payload and records what the output delivers.
  task automatic run_packet(input logic [7:0] typ, input logic [15:0] len, input int rdy_pct,
                            input int bub_at, input int bub_len, input int stop_after,
                            input int max_cyc);
    int idx, bub_left, since_ack, target;
    bit accept, acked, bub_done, done, take, prev_stall;
    logic [8:0] prev_out;
    accept = (int'(len) >= MIN_LEN) && (int'(len) <= MAX_LEN);
    target = !accept ? 0 : (stop_after > 0) ? stop_after : int'(len) + 4;
    obs_q.delete();
    acks = 0; errs = 0; stall_bad = 0; bubbles = 0; vld_seen = 0;
    first_cyc = -1; last_cyc = -1; ack_cyc = -1; timed_out = 0;
    idx = 0; bub_left = 0; since_ack = 0; acked = 0; bub_done = 0; done = 0;
    prev_stall = 0; prev_out = '0;
    pkt_req = 1'b1; pkt_type = typ; pkt_length = len;
    pld_data = 8'hAA; pld_valid = (len != 16'd0);
    t2mi_ready = ($urandom_range(0, 99) < rdy_pct);
    for (int n = 0; n < max_cyc && !done; n++) begin
      @(negedge clk);
      take = pld_valid && pld_ready;
      if (prev_stall && (!t2mi_valid || {t2mi_sync, t2mi_data} !== prev_out)) stall_bad++;
      prev_stall = t2mi_valid && !t2mi_ready;
      prev_out   = {t2mi_sync, t2mi_data};
      if (t2mi_valid) vld_seen++;
      if (pkt_ack) begin acks++; if (!acked) ack_cyc = cyc; end
      if (gen_error) errs++;
      if (t2mi_valid && t2mi_ready) begin
        obs_q.push_back({t2mi_sync, t2mi_data});
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end else if (!t2mi_valid && obs_q.size() > 0) bubbles++;
      if (acked) since_ack++;
      if (pkt_ack) acked = 1;
      done = accept ? (obs_q.size() >= target) : (acked && since_ack >= 4);
      @(posedge clk); #1;
      if (acked) pkt_req = 1'b0;
      if (take) idx++;
      if (bub_at >= 0 && idx == bub_at && !bub_done) begin bub_left = bub_len; bub_done = 1; end
      pld_data  = 8'(32'hAA + idx);
      pld_valid = (idx < int'(len)) && (bub_left == 0);
      if (bub_left > 0) bub_left--;
      t2mi_ready = ($urandom_range(0, 99) < rdy_pct);
    end
    timed_out = !done;
    pkt_req = 1'b0; pld_valid = 1'b0; t2mi_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pkt_req = 1'b1; pkt_length = 16'd10; pld_valid = 1'b1; t2mi_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({t2mi_valid, t2mi_sync, pkt_ack, gen_error, pld_ready, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got v/s/ack/err/rdy/busy=%b want 000000",
               {t2mi_valid, t2mi_sync, pkt_ack, gen_error, pld_ready, busy});
    end
    checks++;
    if (t2mi_data !== 8'h00 || pkt_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got data=%h count=%0d want 00/0", t2mi_data, pkt_count);
    end
    pkt_req = 1'b0; pld_valid = 1'b0; rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bad = 0;
    run_packet(8'h10, 16'd10, 100, -1, 0, 0, 200);
    exp_cnt++;
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(8'h10, 16'd10, k)) bad++;
    checks++;
    if (timed_out || obs_q.size() != 14 || bad != 0) begin
      errors++;
      $display("FAIL basic_stream: got %0d bytes (%0d wrong) want 14 exact", obs_q.size(), bad);
    end
    checks++;
    if (acks != 1 || errs != 0) begin
      errors++; $display("FAIL basic_ack: got acks=%0d errs=%0d want 1/0", acks, errs);
    end
    checks++;
    if (first_cyc != ack_cyc + 1 || last_cyc - first_cyc != 13) begin
      errors++;
      $display("FAIL basic_timing: got sync_lat=%0d span=%0d want 1/13",
               first_cyc - ack_cyc, last_cyc - first_cyc);
    end
    checks++;
    if (pkt_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL basic_count: got %0d want %0d", pkt_count, exp_cnt);
    end
  endtask

  task automatic test_reject();
    logic [15:0] lens[4] = '{16'd2, 16'(MAX_LEN + 1), 16'(MIN_LEN - 1), 16'hFFFF};
    foreach (lens[i]) begin
      run_packet(8'h77, lens[i], 100, -1, 0, 0, 50);
      checks++;
      if (timed_out || acks != 1 || errs != 1 || vld_seen != 0) begin
        errors++;
        $display("FAIL reject_len%0d: got acks=%0d errs=%0d valid_cycles=%0d want 1/1/0",
                 lens[i], acks, errs, vld_seen);
      end
      checks++;
      if (pkt_count !== 16'(exp_cnt)) begin
        errors++; $display("FAIL reject_count: got %0d want %0d", pkt_count, exp_cnt);
      end
    end
  endtask

  task automatic test_random_ready();
    int bad = 0;
    logic [7:0] lastb;
    run_packet(8'h30, 16'd100, 50, -1, 0, 0, 2000);
    exp_cnt++;
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(8'h30, 16'd100, k)) bad++;
    lastb = (obs_q.size() > 0) ? obs_q[$][7:0] : 8'h00;
    checks++;
    if (timed_out || obs_q.size() != 104 || bad != 0) begin
      errors++;
      $display("FAIL stall_stream: got %0d bytes (%0d wrong) want 104 exact", obs_q.size(), bad);
    end
    checks++;
    if (lastb !== 8'h0D) begin errors++; $display("FAIL stall_last: got %h want 0d", lastb); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", stall_bad); end
    checks++;
    if (pkt_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL stall_count: got %0d want %0d", pkt_count, exp_cnt);
    end
  endtask

  task automatic test_bubble();
    int bad = 0;
    run_packet(8'h21, 16'(MIN_LEN), 100, 2, 3, 0, 200);
    exp_cnt++;
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(8'h21, 16'(MIN_LEN), k)) bad++;
    checks++;
    if (timed_out || obs_q.size() != MIN_LEN + 4 || bad != 0) begin
      errors++;
      $display("FAIL bubble_stream: got %0d bytes (%0d wrong) want %0d exact",
               obs_q.size(), bad, MIN_LEN + 4);
    end
    checks++;
    if (bubbles != 3) begin errors++; $display("FAIL bubble_cycles: got %0d want 3", bubbles); end
    checks++;
    if (pkt_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL bubble_count: got %0d want %0d", pkt_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0, last1, n1;
    run_packet(8'h40, 16'd15, 100, -1, 0, 0, 200);
    exp_cnt++;
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(8'h40, 16'd15, k)) bad++;
    last1 = last_cyc; n1 = obs_q.size();
    run_packet(8'h50, 16'd4, 100, -1, 0, 0, 200);
    exp_cnt++;
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(8'h50, 16'd4, k)) bad++;
    checks++;
    if (timed_out || n1 != 19 || obs_q.size() != 8 || bad != 0) begin
      errors++;
      $display("FAIL b2b_stream: got %0d+%0d bytes (%0d wrong) want 19+8", n1, obs_q.size(), bad);
    end
    checks++;
    if (first_cyc - last1 - 1 != IDLE_GAP + 1 || ack_cyc != last1 + IDLE_GAP + 1 || acks != 1) begin
      errors++;
      $display("FAIL b2b_gap: got idle=%0d ack_at=%0d acks=%0d want %0d/%0d/1",
               first_cyc - last1 - 1, ack_cyc - last1, acks, IDLE_GAP + 1, IDLE_GAP + 1);
    end
    checks++;
    if (pkt_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL b2b_count: got %0d want %0d", pkt_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int bad = 0;
      logic [7:0]  typ = 8'($urandom);
      logic [15:0] len = 16'($urandom_range(MIN_LEN, 40));
      run_packet(typ, len, 70, $urandom_range(1, int'(len) - 1), $urandom_range(1, 3), 0, 1000);
      exp_cnt++;
      for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(typ, len, k)) bad++;
      checks++;
      if (timed_out || obs_q.size() != int'(len) + 4 || bad != 0 || stall_bad != 0) begin
        errors++;
        $display("FAIL rand_stream%0d: got %0d bytes (%0d wrong, %0d unstable) want %0d exact",
                 p, obs_q.size(), bad, stall_bad, int'(len) + 4);
      end
    end
    checks++;
    if (pkt_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", pkt_count, exp_cnt);
    end
  endtask

  task automatic test_max_len();
    int bad = 0;
    run_packet(8'h5A, 16'(MAX_LEN), 100, -1, 0, 0, MAX_LEN + 50);
    exp_cnt++;
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(8'h5A, 16'(MAX_LEN), k)) bad++;
    checks++;
    if (timed_out || obs_q.size() != MAX_LEN + 4 || bad != 0 || pkt_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL maxlen: got %0d bytes (%0d wrong) count=%0d want %0d exact count=%0d",
               obs_q.size(), bad, pkt_count, MAX_LEN + 4, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    run_packet(8'h66, 16'd20, 100, -1, 0, 12, 200);
    t2mi_ready = 1'b1; pld_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({t2mi_valid, t2mi_sync, pld_ready, busy} !== 4'b0 || t2mi_data !== 8'h00 ||
        pkt_count !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outs: got v/s/rdy/busy=%b data=%h count=%0d want 0000/00/0",
               {t2mi_valid, t2mi_sync, pld_ready, busy}, t2mi_data, pkt_count);
    end
    exp_cnt = 0;
    pld_valid = 1'b0; t2mi_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_packet(8'h20, 16'd5, 100, -1, 0, 0, 200);
    exp_cnt++;
    for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== exp_byte(8'h20, 16'd5, k)) bad++;
    checks++;
    if (timed_out || obs_q.size() != 9 || bad != 0 || pkt_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL midreset_next: got %0d bytes (%0d wrong) count=%0d want 9 exact count=1",
               obs_q.size(), bad, pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_random_ready();
    test_bubble();
    test_back_to_back();
    test_random();
    test_max_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
